// File: rtl/s1_capture_fifo.sv
// Capture FIFO behind the S1 registered-mux stage: buffers S1 words in arrival
// order and returns them on a registered read port with a one-cycle valid pulse.
module s1_capture_fifo #(
    parameter int size   = 5,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic [size-1:0]   din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [size-1:0]   dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic [size-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [size-1:0]   dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    // wr_en/rd_en are requests with no ready handshake: a write is taken when
    // not full or when a read frees a slot on the same edge; a read is taken
    // when not empty. Refused requests only raise the sticky error flags.
    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign wr_acc = wr_en && (!full || rd_en);
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else if (wr_en) begin
            overflow_d = 1'b1;
        end

        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            dout_d       = mem[rd_ptr_q];
            dout_valid_d = 1'b1;
        end else if (rd_en) begin
            underflow_d = 1'b1;
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is not reset; when full with a simultaneous read, the write lands
    // in the slot being read, and the read still sees the old word (NBA order).
    always_ff @(posedge clk) begin
        if (wr_acc && !CLR) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_s1_capture_fifo.sv
// Bench for s1_capture_fifo: a queue model predicts accepted reads into a
// scoreboard; directed scenarios then a randomized run.
module tb_s1_capture_fifo;

    localparam int W  = 5;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          CLR;
    logic [W-1:0]  din;
    logic          wr_en;
    logic          rd_en;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    int vec_cnt     = 0;
    int miscompares = 0;

    logic [W-1:0] mdl_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_dout;
    logic         m_valid;
    logic         m_ovf;
    logic         m_udf;

    s1_capture_fifo #(.size(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk        (clk),
        .CLR        (CLR),
        .din        (din),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        exp_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        logic [W-1:0] e;
        chk({tag, "_count"}, 32'(count), 32'(mdl_q.size()));
        chk({tag, "_full"}, 32'(full), 32'(mdl_q.size() == D));
        chk({tag, "_empty"}, 32'(empty), 32'(mdl_q.size() == 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_udf"}, 32'(underflow), 32'(m_udf));
        chk({tag, "_dvalid"}, 32'(dout_valid), 32'(m_valid));
        if (m_valid) begin
            e = exp_q.pop_front();
            chk({tag, "_sb_dout"}, 32'(dout), 32'(e));
        end else begin
            chk({tag, "_hold_dout"}, 32'(dout), 32'(m_dout));
        end
    endtask

    // Called at a falling edge; drives one request set for the next rising edge.
    task automatic cycle(input logic we, input logic re, input logic [W-1:0] d, input string tag);
        logic rd_acc;
        logic wr_acc;
        wr_en = we;
        rd_en = re;
        din   = d;
        @(posedge clk);
        rd_acc  = re && (mdl_q.size() > 0);
        wr_acc  = we && ((mdl_q.size() < D) || re);
        m_valid = rd_acc;
        if (rd_acc) begin
            m_dout = mdl_q.pop_front();
            exp_q.push_back(m_dout);
        end
        if (re && !rd_acc) m_udf = 1'b1;
        if (we && !wr_acc) m_ovf = 1'b1;
        if (wr_acc) mdl_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    // Asynchronous clear between edges, checked before any clock edge occurs.
    task automatic mid_clear(input string tag);
        CLR = 1'b1;
        #1;
        model_reset();
        check_state(tag);
        #2;
        CLR = 1'b0;
    endtask

    task automatic drain(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, '0, tag);
    endtask

    initial begin
        CLR   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #1;
        model_reset();
        check_state("reset");
        @(negedge clk);
        CLR = 1'b0;

        // fill and drain
        cycle(1'b1, 1'b0, 5'h03, "fill");
        cycle(1'b1, 1'b0, 5'h1F, "fill");
        cycle(1'b1, 1'b0, 5'h0A, "fill");
        cycle(1'b1, 1'b0, 5'h11, "fill");
        chk("fill_full_flag", 32'(full), 32'd1);
        chk("fill_count4", 32'(count), 32'd4);
        cycle(1'b0, 1'b1, '0, "drain");
        chk("drain_first", 32'(dout), 32'h03);
        drain(3, "drain");
        chk("drain_last", 32'(dout), 32'h11);
        chk("drain_empty", 32'(empty), 32'd1);

        // overflow: 5'h15 is dropped and must never reach the scoreboard
        for (int i = 6; i < 10; i++) cycle(1'b1, 1'b0, W'(i), "ovf_fill");
        cycle(1'b1, 1'b0, 5'h15, "ovf_write");
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd4);
        drain(4, "ovf_drain");
        chk("ovf_last", 32'(dout), 32'h09);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        cycle(1'b0, 1'b0, '0, "ovf_idle");
        mid_clear("clr_mid");

        // full with simultaneous read and write
        for (int i = 1; i < 5; i++) cycle(1'b1, 1'b0, W'(i), "frw_fill");
        cycle(1'b1, 1'b1, 5'h05, "frw_rw");
        chk("frw_dout", 32'(dout), 32'h01);
        chk("frw_count", 32'(count), 32'd4);
        chk("frw_no_ovf", 32'(overflow), 32'd0);
        drain(4, "frw_drain");
        chk("frw_last", 32'(dout), 32'h05);

        // empty with simultaneous read and write
        cycle(1'b1, 1'b1, 5'h1A, "erw_rw");
        chk("erw_udf", 32'(underflow), 32'd1);
        chk("erw_dvalid", 32'(dout_valid), 32'd0);
        chk("erw_count", 32'(count), 32'd1);
        cycle(1'b0, 1'b1, '0, "erw_read");
        chk("erw_dout", 32'(dout), 32'h1A);
        mid_clear("clr_erw");

        // wrap-around stream then clear with two words held
        for (int i = 0; i < 10; i++) cycle(1'b1, i > 0, W'(i), "wrap");
        cycle(1'b0, 1'b1, '0, "wrap_tail");
        chk("wrap_last", 32'(dout), 32'h09);
        cycle(1'b1, 1'b0, 5'h1C, "wrap_fill");
        cycle(1'b1, 1'b0, 5'h1D, "wrap_fill");
        chk("wrap_count2", 32'(count), 32'd2);
        mid_clear("clr_wrap");
        chk("clr_wrap_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b1, '0, "post_clr_rd");
        chk("post_clr_udf", 32'(underflow), 32'd1);
        chk("post_clr_dout", 32'(dout), 32'h00);

        // randomized traffic
        mid_clear("clr_rand");
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                  W'($urandom_range(0, 31)), "rand");
        end
        drain(D + 1, "rand_drain");
        chk("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
